// File: rtl/synapse_wb_pkg.sv
// Shared types and constants for the synapse Wishbone burst master.
package synapse_wb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_BUS     = 3'd2,
      ST_DELIVER = 3'd3,
      ST_GAP     = 3'd4,
      ST_DONE    = 3'd5
   } wbm_state_t;

   localparam logic [3:0]  WB_SEL_ALL    = 4'hF;
   localparam logic [31:0] SYNAPSE_BASE  = 32'h3000_0000;
   localparam int          SYNAPSE_WORDS = 256;

endpackage

// File: rtl/wb_ack_timeout.sv
// Ack watchdog: down-counter reloaded whenever the bus is idle or acked,
// expire_o flags the last cycle of a TIMEOUT_CYC-long wait.
module wb_ack_timeout #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic expire_o
);

   localparam int CNT_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q;

   // reload outside a wait, count down while the cycle is outstanding
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= LOAD_VAL;
      end else if (!run || clear) begin
         cnt_q <= LOAD_VAL;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // terminal count reached while still waiting
   always_comb begin
      expire_o = run && !clear && (cnt_q == '0);
   end

endmodule

// File: rtl/synapse_wb_master.sv
// Wishbone classic burst master for the synapse_matrix slave port.
// Optional ack watchdog enabled by defining SYNAPSE_WB_TIMEOUT_EN.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | ready for a command
// ST_FETCH   | write burst: waiting for the next word on the write stream
// ST_BUS     | single-beat Wishbone cycle outstanding
// ST_DELIVER | read burst: holding the returned word until consumed
// ST_GAP     | one dead cycle between bus cycles, address advance
// ST_DONE    | one-cycle completion pulse
module synapse_wb_master
   import synapse_wb_pkg::*;
#(
   parameter int LEN_W       = 9,
   parameter int ADR_STRIDE  = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic             cmd_we_i,
   input  logic [31:0]      cmd_adr_i,
   input  logic [LEN_W-1:0] cmd_len_i,
   input  logic [31:0]      wr_data_i,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   output logic [31:0]      rd_data_o,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [31:0]      wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic [31:0]      wbm_dat_i,
   input  logic             wbm_ack_i
);

   wbm_state_t       state_q, state_d;
   logic [31:0]      adr_q;
   logic [LEN_W-1:0] cnt_q;
   logic             we_q;
   logic [31:0]      wr_dat_q;
   logic [31:0]      rd_dat_q;
   logic             tmo_expire;

   logic in_bus;
   assign in_bus = (state_q == ST_BUS);

`ifdef SYNAPSE_WB_TIMEOUT_EN
   logic err_q;

   wb_ack_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_ack_timeout (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .run      (in_bus),
      .clear    (wbm_ack_i),
      .expire_o (tmo_expire)
   );

   // sticky abort flag, cleared when a new command is taken
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         err_q <= 1'b0;
      end else if (state_q == ST_IDLE && cmd_valid_i) begin
         err_q <= 1'b0;
      end else if (in_bus && !wbm_ack_i && tmo_expire) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign tmo_expire = 1'b0;
   assign err_o      = 1'b0;
`endif

   // state register
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state decode; a stray ack outside ST_BUS is ignored
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               if (cmd_len_i == '0) state_d = ST_DONE;
               else if (cmd_we_i)   state_d = ST_FETCH;
               else                 state_d = ST_BUS;
            end
         end
         ST_FETCH: begin
            if (wr_valid_i) state_d = ST_BUS;
         end
         ST_BUS: begin
            if (wbm_ack_i)       state_d = we_q ? ST_GAP : ST_DELIVER;
            else if (tmo_expire) state_d = ST_DONE;
         end
         ST_DELIVER: begin
            if (rd_ready_i) state_d = ST_GAP;
         end
         ST_GAP: begin
            if (cnt_q == '0) state_d = ST_DONE;
            else if (we_q)   state_d = ST_FETCH;
            else             state_d = ST_BUS;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // burst datapath: command latch, word capture, count and address update
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         adr_q    <= '0;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         wr_dat_q <= '0;
         rd_dat_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  adr_q <= cmd_adr_i;
                  cnt_q <= cmd_len_i;
                  we_q  <= cmd_we_i;
               end
            end
            ST_FETCH: begin
               if (wr_valid_i) wr_dat_q <= wr_data_i;
            end
            ST_BUS: begin
               if (wbm_ack_i) begin
                  if (we_q) cnt_q    <= cnt_q - LEN_W'(1);
                  else      rd_dat_q <= wbm_dat_i;
               end
            end
            ST_DELIVER: begin
               if (rd_ready_i) cnt_q <= cnt_q - LEN_W'(1);
            end
            ST_GAP: begin
               // last word leaves the address on the final bus address
               if (cnt_q != '0) adr_q <= adr_q + 32'(ADR_STRIDE);
            end
            default: begin
            end
         endcase
      end
   end

   // state-decoded handshakes and bus outputs
   always_comb begin
      cmd_ready_o = (state_q == ST_IDLE);
      wr_ready_o  = (state_q == ST_FETCH);
      rd_valid_o  = (state_q == ST_DELIVER);
      busy_o      = (state_q != ST_IDLE);
      done_o      = (state_q == ST_DONE);
      wbm_cyc_o   = in_bus;
      wbm_stb_o   = in_bus;
      wbm_we_o    = in_bus && we_q;
      wbm_sel_o   = in_bus ? WB_SEL_ALL : 4'h0;
      wbm_adr_o   = adr_q;
      wbm_dat_o   = wr_dat_q;
      rd_data_o   = rd_dat_q;
   end

endmodule
